// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: PC-unit side, instruction memory port and decode handshake.
// master = environment (PC unit, memory, decode); slave = fetch_buffer.
interface fetch_buffer_if #(
  parameter int unsigned SIZE = 32
) ();
  logic [SIZE-1:0] pc;
  logic            PCSE;
  logic            stallF;
  logic [SIZE-1:0] imem_addr;
  logic [SIZE-1:0] imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [SIZE-1:0] dec_instr;
  logic [SIZE-1:0] dec_pc;

  modport master (
    output pc, PCSE, imem_rdata, dec_ready,
    input  stallF, imem_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    input  pc, PCSE, imem_rdata, dec_ready,
    output stallF, imem_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues pc to synchronous imem, queues {instr, pc} for decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module fetch_buffer #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [SIZE-1:0] instr_q [DEPTH];
  logic [SIZE-1:0] epc_q   [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q;
  logic            req_q;
  logic [SIZE-1:0] pc_q;

  logic [AW+1:0] occ;
  logic          issue, push, pop, byp;

  // Credit counts the in-flight word so a push can never hit a full FIFO.
  assign occ        = {1'b0, count_q} + {{(AW + 1){1'b0}}, req_q};
  assign bus.stallF = bus.PCSE | (occ < (AW + 2)'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign byp = (count_q == '0) & req_q & ~bus.PCSE;
`else
  assign byp = 1'b0;
`endif

  assign bus.imem_addr = bus.pc;
  assign bus.dec_valid = ((count_q != '0) | byp) & ~bus.PCSE;
  assign bus.dec_instr = byp ? bus.imem_rdata : instr_q[rptr_q];
  assign bus.dec_pc    = byp ? pc_q : epc_q[rptr_q];

  assign issue = bus.stallF & ~bus.PCSE;
  assign push  = req_q & ~bus.PCSE & ~(byp & bus.dec_ready);
  assign pop   = (count_q != '0) & ~bus.PCSE & bus.dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      pc_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else if (bus.PCSE) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc_q <= bus.pc;
      end
      if (push) begin
        instr_q[wptr_q] <= bus.imem_rdata;
        epc_q[wptr_q]   <= pc_q;
        wptr_q          <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: scoreboard monitor plus directed timing checks.
module tb_fetch_buffer;
  localparam int unsigned SIZE  = 32;
  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] target = 32'h0;
  exp_t        expq[$];
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;

  always #5 clk = ~clk;

  fetch_buffer_if #(.SIZE(SIZE)) bus ();

  fetch_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PC register driven by stallF, and a synchronous memory returning addr + 0x1000.
  always @(posedge clk) begin
    if (rst)           bus.pc <= 32'h0;
    else if (bus.PCSE) bus.pc <= target;
    else if (bus.stallF) bus.pc <= bus.pc + 32'h4;
  end

  always @(posedge clk) bus.imem_rdata <= bus.imem_addr + 32'h1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.PCSE = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Monitor: every issued fetch is expected at decode in order unless a redirect drops it.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      expq.delete();
    end else if (bus.PCSE) begin
      check("valid_during_redirect", 32'(bus.dec_valid), 32'h0);
      expq.delete();
    end else begin
      if (bus.dec_valid && bus.dec_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got dec_pc=0x%0h, expected no entry", bus.dec_pc);
        end else begin
          e = expq.pop_front();
          check("sb_dec_pc", bus.dec_pc, e.pc);
          check("sb_dec_instr", bus.dec_instr, e.instr);
          pops++;
        end
      end
      if (bus.stallF) expq.push_back('{pc: bus.pc, instr: bus.pc + 32'h1000});
      check("occupancy_le_depth", 32'(expq.size() <= int'(DEPTH)), 32'h1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bus.PCSE      = 1'b0;
    bus.dec_ready = 1'b1;

    // Reset, then stream.
    do_reset();
    check("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
    check("rst_dec_instr", bus.dec_instr, 32'h0);
    check("rst_dec_pc", bus.dec_pc, 32'h0);
    check("rst_stallF", 32'(bus.stallF), 32'h1);
    check("first_issue_addr", bus.imem_addr, 32'h0);
    step(LAT);
    for (int k = 0; k < 3; k++) begin
      check("stream_valid", 32'(bus.dec_valid), 32'h1);
      check("stream_pc", bus.dec_pc, 32'(4 * k));
      check("stream_instr", bus.dec_instr, 32'h1000 + 32'(4 * k));
      check("stream_stallF", 32'(bus.stallF), 32'h1);
      step(1);
    end

    // Back-pressure: four issues then stall, drain in order.
    bus.dec_ready = 1'b0;
    do_reset();
    step(3);
    check("bp_stallF_c4", 32'(bus.stallF), 32'h1);
    step(1);
    check("bp_stallF_c5", 32'(bus.stallF), 32'h0);
    step(2);
    check("bp_stallF_c7", 32'(bus.stallF), 32'h0);
    check("bp_held_addr", bus.imem_addr, 32'h10);
    bus.dec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_drain_valid", 32'(bus.dec_valid), 32'h1);
      check("bp_drain_pc", bus.dec_pc, 32'(4 * k));
      step(1);
    end
    step(3);

    // Redirect with two queued entries and one in flight.
    bus.dec_ready = 1'b0;
    do_reset();
    step(3);
    bus.PCSE = 1'b1;
    target   = 32'h80;
    #1;
    check("redir_dec_valid", 32'(bus.dec_valid), 32'h0);
    check("redir_stallF", 32'(bus.stallF), 32'h1);
    step(1);
    bus.PCSE      = 1'b0;
    bus.dec_ready = 1'b1;
    check("redir_target_issue", bus.imem_addr, 32'h80);
    check("redir_empty_valid", 32'(bus.dec_valid), 32'h0);
    check("redir_stallF_next", 32'(bus.stallF), 32'h1);
    step(LAT);
    check("redir_first_valid", 32'(bus.dec_valid), 32'h1);
    check("redir_first_pc", bus.dec_pc, 32'h80);
    check("redir_first_instr", bus.dec_instr, 32'h1080);
    step(4);

    // Wrap-around with alternating decode readiness.
    bus.dec_ready = 1'b0;
    do_reset();
    p0 = pops;
    for (int i = 0; i < 30; i++) begin
      bus.dec_ready = (i % 2) == 1;
      step(1);
    end
    check("wrap_pop_count", 32'((pops - p0) >= 10), 32'h1);
    bus.dec_ready = 1'b1;
    step(6);

    // Reset while nearly full with a request in flight.
    bus.dec_ready = 1'b0;
    do_reset();
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_full_valid", 32'(bus.dec_valid), 32'h0);
    check("rst_full_stallF", 32'(bus.stallF), 32'h1);
    check("rst_full_pc", bus.dec_pc, 32'h0);
    step(LAT);
    check("rst_full_head_pc", bus.dec_pc, 32'h0);
    check("rst_full_head_instr", bus.dec_instr, 32'h1000);
    bus.dec_ready = 1'b1;
    step(4);

    // Reset and redirect together behave as reset alone.
    rst      = 1'b1;
    bus.PCSE = 1'b1;
    target   = 32'h80;
    step(1);
    rst      = 1'b0;
    bus.PCSE = 1'b0;
    check("rstpcse_valid", 32'(bus.dec_valid), 32'h0);
    check("rstpcse_stallF", 32'(bus.stallF), 32'h1);
    check("rstpcse_dec_pc", bus.dec_pc, 32'h0);
    check("rstpcse_dec_instr", bus.dec_instr, 32'h0);
    check("rstpcse_issue_addr", bus.imem_addr, 32'h0);
    step(LAT);
    check("rstpcse_first_valid", 32'(bus.dec_valid), 32'h1);
    check("rstpcse_first_pc", bus.dec_pc, 32'h0);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
